// File: rtl/alu_seq_if.sv
// Request/response handshake bundle for the execute-stage ALU sequencer.
// master issues requests and consumes results; slave is the sequencer.
interface alu_seq_if #(
    parameter int DATA_WIDTH = 8,
    parameter int COUNT_W    = 4
);
    logic                  req_valid;
    logic                  req_ready;
    logic [4:0]            req_opcode;
    logic [DATA_WIDTH-1:0] req_a;
    logic [DATA_WIDTH-1:0] req_b;
    logic [COUNT_W-1:0]    req_count;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_result;
    logic [3:0]            rsp_status;

    modport master (
        output req_valid,
        output req_opcode,
        output req_a,
        output req_b,
        output req_count,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_result,
        input  rsp_status
    );

    modport slave (
        input  req_valid,
        input  req_opcode,
        input  req_a,
        input  req_b,
        input  req_count,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_result,
        output rsp_status
    );
endinterface

// File: rtl/alu_seq.sv
// Execute-stage sequencer: drives the ALU, iterates 1-bit shifts,
// returns result/status over a valid/ready port and keeps flags.
module alu_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int COUNT_W    = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    alu_seq_if.slave              bus,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [4:0]            alu_opcode,
    input  logic [DATA_WIDTH-1:0] alu_c,
    input  logic [3:0]            alu_status,
    output logic [3:0]            flags,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        SHIFT,
        DONE
    } state_t;

    localparam logic [COUNT_W-1:0] MAX_CNT = COUNT_W'(DATA_WIDTH);
    localparam logic [COUNT_W-1:0] ONE     = COUNT_W'(1);

    state_t                state;
    state_t                state_nxt;
    logic [4:0]            op_q;
    logic [DATA_WIDTH-1:0] work_a;
    logic [DATA_WIDTH-1:0] b_q;
    logic [COUNT_W-1:0]    remaining;
    logic [COUNT_W-1:0]    cnt_clamp;
    logic [DATA_WIDTH-1:0] result_q;
    logic [3:0]            status_q;
    logic [3:0]            flags_q;
    logic                  accept;
    logic                  is_shift;
    logic                  last_step;
    logic                  capture;

    always_comb begin
        cnt_clamp = bus.req_count;
        if (bus.req_count > MAX_CNT)
            cnt_clamp = MAX_CNT;
    end

    assign accept    = bus.req_valid && (state == IDLE);
    assign is_shift  = bus.req_opcode[4];
    assign last_step = (state == SHIFT) && (remaining == ONE);
    assign capture   = (state == EXEC) || last_step;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (is_shift && (cnt_clamp != '0))
                        state_nxt = SHIFT;
                    else
                        state_nxt = EXEC;
                end
            end
            EXEC:  state_nxt = DONE;
            SHIFT: begin
                if (remaining == ONE)
                    state_nxt = DONE;
            end
            DONE: begin
                if (bus.rsp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q      <= '0;
            work_a    <= '0;
            b_q       <= '0;
            remaining <= '0;
            result_q  <= '0;
            status_q  <= '0;
            flags_q   <= '0;
        end else begin
            if (accept) begin
                // zero-count shift runs as LD so status is fresh for A
                if (is_shift && (cnt_clamp == '0))
                    op_q <= 5'h00;
                else
                    op_q <= bus.req_opcode;
                work_a    <= bus.req_a;
                b_q       <= bus.req_b;
                remaining <= cnt_clamp;
            end
            if (state == SHIFT) begin
                work_a    <= alu_c;
                remaining <= remaining - ONE;
            end
            if (capture) begin
                result_q <= alu_c;
                status_q <= alu_status;
                flags_q  <= alu_status;
            end
        end
    end

    assign alu_a          = work_a;
    assign alu_b          = b_q;
    assign alu_opcode     = op_q;
    assign bus.req_ready  = (state == IDLE);
    assign bus.rsp_valid  = (state == DONE);
    assign bus.rsp_result = result_q;
    assign bus.rsp_status = status_q;
    assign flags          = flags_q;
    assign busy           = (state != IDLE);

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Execute-stage sequencer sitting directly upstream of the ALU.
- Accepts one operation request (opcode, operands, shift count) over a valid/ready handshake.
- Drives the combinational ALU inputs and captures the ALU result and status.
- Iterates the ALU's single-bit LSH/RSH to implement multi-bit shifts.
- Returns the result over a valid/ready response port and keeps a persistent flags register for the control unit.

Parameters:
- DATA_WIDTH, 8, operand/result width; must match the ALU.
- COUNT_W, 4, width of the shift-count field; must be at least clog2(DATA_WIDTH)+1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request (high only in IDLE).
- req_opcode  input  5  ALU opcode, same encoding as the ALU.
- req_a  input  DATA_WIDTH  operand A.
- req_b  input  DATA_WIDTH  operand B.
- req_count  input  COUNT_W  shift amount; ignored unless req_opcode[4]=1.
- alu_a  output  DATA_WIDTH  to ALU A.
- alu_b  output  DATA_WIDTH  to ALU B.
- alu_opcode  output  5  to ALU opcode.
- alu_c  input  DATA_WIDTH  ALU result.
- alu_status  input  4  ALU status {sign, zero, parity, carry}.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts the result.
- rsp_result  output  DATA_WIDTH  captured result.
- rsp_status  output  4  captured status {sign, zero, parity, carry}.
- flags  output  4  last completed operation's status; persists across idle.
- busy  output  1  state is not IDLE.

Behaviour:
- States: IDLE, EXEC, SHIFT, DONE.
- Reset (asynchronous, reset_n=0):
  - state goes to IDLE immediately.
  - rsp_valid, rsp_result, rsp_status, flags, busy, alu_a, alu_b, alu_opcode are all 0.
  - All internal registers are cleared.
  - Reset mid-operation abandons the operation with no response.
- IDLE: req_ready=1. On req_valid&&req_ready:
  - Latch opcode, A into work_a, B, and count clamped to DATA_WIDTH (any count > DATA_WIDTH is treated as DATA_WIDTH).
  - Go to SHIFT if opcode[4]=1 and the clamped count is nonzero; otherwise go to EXEC.
- ALU drive:
  - alu_a = work_a, alu_b = latched B.
  - alu_opcode = latched opcode, except a shift with count 0 drives 5'h00 (LD), so the result equals A with fresh status.
  - Outputs are registered or derived from registers only; no combinational path from req_* to alu_*.
- EXEC (one cycle): at the next edge capture alu_c into rsp_result and alu_status into rsp_status and flags, then go to DONE.
- SHIFT, with remaining = clamped count:
  - Each edge: work_a <= alu_c, remaining <= remaining-1.
  - On the edge where remaining==1: also capture alu_c and alu_status into rsp_result, rsp_status and flags, then go to DONE.
  - Status therefore reflects the final 1-bit step only; carry = last bit shifted out on LSH, 0 on RSH.
- Latency, counted from the accept edge:
  - Non-shift op, and shift with count 0: rsp_valid is high after 1 edge.
  - Shift by N≥1: rsp_valid is high after N edges.
- DONE:
  - rsp_valid=1; rsp_result and rsp_status are held stable while rsp_ready=0 (unbounded backpressure).
  - On rsp_ready=1: go to IDLE and drop rsp_valid. rsp_result, rsp_status and flags retain their values.
  - req_ready=0 in DONE; a request presented during DONE is not accepted until the IDLE cycle that follows.
- Throughput: at most one op per (latency+1) cycles; requests are never dropped, they wait in valid-high.
- flags changes only at capture edges and on reset.
- Widths: all ALU arithmetic, including the carry/9th bit, is done by the ALU. This block performs no arithmetic other than the count decrement and clamp.
- Opcode classes:
  - Any opcode with bit4=1 is a shift: 5'h10–5'h17 is RSH, 5'h18–5'h1F is LSH, decided by the ALU.
  - All others execute single-cycle.

Test Plan (DATA_WIDTH=8):
- ADD: opcode 5'h02, A=200, B=100 -> rsp_valid 1 cycle after accept; rsp_result=44; rsp_status=4'b0011; flags=4'b0011.
- SUB: opcode 5'h05, A=5, B=5 -> rsp_result=0; rsp_status=4'b0100; busy high exactly from accept until the rsp handshake.
- LSH: opcode 5'h18, A=8'h81, count=3 -> rsp_valid 3 cycles after accept; rsp_result=8'h08; rsp_status=4'b0010; alu_a sequence 81, 02, 04.
- RSH count 0: opcode 5'h10, A=8'hF0, count=0 -> alu_opcode=0; rsp_result=8'hF0; rsp_status=4'b1000 after 1 cycle.
- RSH count clamp: count=15 -> clamped to 8; rsp_result=0; rsp_status=4'b0100 after 8 cycles.
- Backpressure: hold rsp_ready=0 for 5 cycles with a new req_valid asserted -> rsp_result/rsp_status stable; req_ready=0; the new request is accepted only in the IDLE cycle after the rsp handshake.
- Reset mid-shift: start an LSH with count=8, pull reset_n low on cycle 3 -> all outputs 0 in the same cycle with no clock edge needed; after release req_ready=1 and no rsp_valid from the aborted op.
